// File: rtl/rob_commit_if.sv
// Issue, writeback and retire signals of the reorder buffer, bundled for port connection.
// The master side drives allocation and writeback. The slave side is the ROB itself.
interface rob_commit_if #(
    parameter int DEPTH = 8,
    parameter int DW    = 16,
    parameter int NWB   = 4,
    parameter int IW    = $clog2(DEPTH)
);
    logic              alloc_valid;
    logic [3:0]        alloc_rd;
    logic [3:0]        alloc_func;
    logic              alloc_ready;
    logic [IW-1:0]     alloc_idx;
    logic [NWB-1:0]    wb_valid;
    logic [NWB*IW-1:0] wb_rob;
    logic [NWB*DW-1:0] wb_data;
    logic              commit_valid;
    logic              commit_we;
    logic [3:0]        commit_rd;
    logic [DW-1:0]     commit_data;
    logic [IW-1:0]     commit_rob;
    logic              wb_err;
    logic [IW:0]       count;

    modport master (
        output alloc_valid, alloc_rd, alloc_func, wb_valid, wb_rob, wb_data,
        input  alloc_ready, alloc_idx, commit_valid, commit_we, commit_rd,
               commit_data, commit_rob, wb_err, count
    );

    modport slave (
        input  alloc_valid, alloc_rd, alloc_func, wb_valid, wb_rob, wb_data,
        output alloc_ready, alloc_idx, commit_valid, commit_we, commit_rd,
               commit_data, commit_rob, wb_err, count
    );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer for the add/mul execution units. It allocates entries in program order,
// captures results from the writeback ports, and retires at most one entry per cycle, in order.
module rob_commit_unit #(
    parameter int DEPTH = 8,
    parameter int DW    = 16,
    parameter int NWB   = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input logic         clk1,
    input logic         rst,
    rob_commit_if.slave bus
);
    localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] done_q;
    logic [3:0]       func_q [DEPTH];
    logic [3:0]       rd_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [IW-1:0]    head_q;
    logic [IW-1:0]    tail_q;
    logic [IW:0]      count_q;

    logic             commit_valid_q;
    logic             commit_we_q;
    logic [3:0]       commit_rd_q;
    logic [DW-1:0]    commit_data_q;
    logic [IW-1:0]    commit_rob_q;
    logic             wb_err_q;

    logic             alloc_ready;
    logic             alloc_fire;
    logic             commit_fire;
    logic [IW-1:0]    wb_idx [NWB];
    logic [NWB-1:0]   wb_ok;
    logic             wb_bad;

    assign alloc_ready = (count_q < FULL);
    assign alloc_fire  = bus.alloc_valid && alloc_ready;
    assign commit_fire = busy_q[head_q] && done_q[head_q];

    // Each port is legal only if it targets a busy, undone entry that no lower port
    // already claimed this cycle. All checks use the state before the edge.
    always_comb begin
        wb_idx = '{default: '0};
        wb_ok  = '0;
        wb_bad = 1'b0;
        for (int i = 0; i < NWB; i++) begin
            wb_idx[i] = bus.wb_rob[i*IW +: IW];
            wb_ok[i]  = bus.wb_valid[i] && busy_q[wb_idx[i]] && !done_q[wb_idx[i]];
            for (int j = 0; j < i; j++) begin
                if (bus.wb_valid[j] && (wb_idx[j] == wb_idx[i])) begin
                    wb_ok[i] = 1'b0;
                end
            end
            if (bus.wb_valid[i] && !wb_ok[i]) begin
                wb_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_we_q    <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            commit_rob_q   <= '0;
            wb_err_q       <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                func_q[k] <= '0;
                rd_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else begin
            wb_err_q       <= wb_bad;
            commit_valid_q <= commit_fire;
            if (commit_fire) begin
                // Func codes 0..3 (add/sub/mul/div) are the only ones that write a register.
                commit_we_q    <= (func_q[head_q] <= 4'd3);
                commit_rd_q    <= rd_q[head_q];
                commit_data_q  <= data_q[head_q];
                commit_rob_q   <= head_q;
                busy_q[head_q] <= 1'b0;
                done_q[head_q] <= 1'b0;
                head_q         <= head_q + 1'b1;
            end
            for (int i = 0; i < NWB; i++) begin
                if (wb_ok[i]) begin
                    done_q[wb_idx[i]] <= 1'b1;
                    data_q[wb_idx[i]] <= bus.wb_data[i*DW +: DW];
                end
            end
            // The tail entry is never busy when allocation fires, so no writeback can hit it here.
            if (alloc_fire) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
                func_q[tail_q] <= bus.alloc_func;
                rd_q[tail_q]   <= bus.alloc_rd;
                data_q[tail_q] <= '0;
                tail_q         <= tail_q + 1'b1;
            end
            count_q <= count_q + {{IW{1'b0}}, alloc_fire} - {{IW{1'b0}}, commit_fire};
        end
    end

    assign bus.alloc_ready  = alloc_ready;
    assign bus.alloc_idx    = tail_q;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_we    = commit_we_q;
    assign bus.commit_rd    = commit_rd_q;
    assign bus.commit_data  = commit_data_q;
    assign bus.commit_rob   = commit_rob_q;
    assign bus.wb_err       = wb_err_q;
    assign bus.count        = count_q;
endmodule
